// File: rtl/audio_pkg.sv
// Shared types and default sizing for the audio-out path.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 32;
    localparam int AUDIO_FIFO_DEPTH = 8;

    // Serializer channel phase; IDLE is only left by the first LRCK rising edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small sample-pair FIFO with show-ahead read data: the head entry is always
// presented on rd_data so the serializer can load it in the same cycle it pops.
module audio_sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg;
    logic             do_push, do_pop;

    // Flush overrides both push and pop; a full FIFO drops writes.
    assign do_push = push & ~full_reg & ~flush;
    assign do_pop  = pop & (count_reg != '0) & ~flush;

    // Next pointer/count values; pointers wrap naturally since DEPTH is 2^AW.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer, count and registered full flag.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == CW'(DEPTH));
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/audio_dac_serializer.sv
// WM8731 DAC-side serializer: buffers stereo pairs and shifts them MSB-first
// in left-justified slave mode, timed by the codec's BCLK/DACLRCK.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  audio_out_allowed,
    output logic                  AUD_DACDAT,
    output logic                  dac_underflow
);

    // Bit 0 = BCLK, bit 1 = DACLRCK.
    logic [1:0] pin_raw, pin_sync, pin_prev;
    logic       bclk_fall, lrck_rise, lrck_fall;

    assign pin_raw = {AUD_DACLRCK, AUD_BCLK};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg, sync_reg, prev_reg;
            // Two-flop synchronizer plus edge register. Left unreset so the
            // chain keeps tracking the pins during reset and no phantom edge
            // appears on release.
            always_ff @(posedge CLOCK_50) begin
                meta_reg <= pin_raw[gi];
                sync_reg <= meta_reg;
                prev_reg <= sync_reg;
            end
            assign pin_sync[gi] = sync_reg;
            assign pin_prev[gi] = prev_reg;
        end
    endgenerate

    assign bclk_fall = pin_prev[0] & ~pin_sync[0];
    assign lrck_rise = ~pin_prev[1] & pin_sync[1];
    assign lrck_fall = pin_prev[1] & ~pin_sync[1];

    logic [2*DATA_WIDTH-1:0]        fifo_rd_data;
    logic                           fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    assign fifo_pop = lrck_rise & (fifo_count != '0);

    audio_sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (write_audio_out & audio_out_allowed),
        .pop      (fifo_pop),
        .flush    (clear_audio_out_memory),
        .wr_data  ({left_channel_audio_out, right_channel_audio_out}),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    ser_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] right_hold_reg, right_hold_next;
    logic                  underflow_reg, underflow_next;
    logic                  dacdat_reg;

    // Next state: LRCK edges load words (and block shifting), BCLK falls shift.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        right_hold_next = right_hold_reg;
        underflow_next  = 1'b0;
        if (lrck_rise) begin
            state_next = LEFT;
            if (!fifo_empty) begin
                shift_next      = fifo_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                right_hold_next = fifo_rd_data[DATA_WIDTH-1:0];
            end else begin
                shift_next      = '0;
                right_hold_next = '0;
                underflow_next  = 1'b1;
            end
        end else if (lrck_fall) begin
            if (state_reg == LEFT) begin
                shift_next = right_hold_reg;
                state_next = RIGHT;
            end
        end else if (bclk_fall) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Serializer registers and registered serial output.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            right_hold_reg <= '0;
            underflow_reg  <= 1'b0;
            dacdat_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            right_hold_reg <= right_hold_next;
            underflow_reg  <= underflow_next;
            dacdat_reg     <= shift_reg[DATA_WIDTH-1];
        end
    end

    assign audio_out_allowed = ~fifo_full;
    assign AUD_DACDAT        = dacdat_reg;
    assign dac_underflow     = underflow_reg;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Scoreboarded bench: a codec model drives BCLK/DACLRCK, a queue model of the
// FIFO predicts each frame's bit stream, and monitors compare DACDAT at every
// BCLK rising edge and count dac_underflow pulses.
module tb_audio_dac_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int HALF  = 8;   // CLOCK_50 cycles per BCLK half period (3.125 MHz)

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          clear_audio_out_memory = 1'b0;
    logic [DW-1:0] left_channel_audio_out = '0;
    logic [DW-1:0] right_channel_audio_out = '0;
    logic          write_audio_out = 1'b0;
    logic          AUD_BCLK = 1'b1;
    logic          AUD_DACLRCK = 1'b0;
    logic          audio_out_allowed;
    logic          AUD_DACDAT;
    logic          dac_underflow;

    audio_dac_serializer dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .clear_audio_out_memory  (clear_audio_out_memory),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out),
        .AUD_BCLK                (AUD_BCLK),
        .AUD_DACLRCK             (AUD_DACLRCK),
        .audio_out_allowed       (audio_out_allowed),
        .AUD_DACDAT              (AUD_DACDAT),
        .dac_underflow           (dac_underflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int vectors = 0;
    int miscompares = 0;

    logic [2*DW-1:0] mq[$];       // model FIFO contents, {left, right}
    bit              exp_bits[$]; // scoreboard of expected DACDAT bits
    int              exp_uf = 0;
    int              uf_seen = 0;
    bit              mon_en = 0;
    int              frame_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check_allowed(input string name);
        check(name, 64'(audio_out_allowed), 64'(mq.size() < DEPTH));
    endtask

    // Serial-data monitor: one expected bit per codec sampling edge.
    initial begin
        int bit_no = 0;
        forever begin
            @(posedge AUD_BCLK);
            if (mon_en) begin
                if (exp_bits.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dacdat_unexpected: got %0b, expected no sample edge", AUD_DACDAT);
                end else begin
                    bit e;
                    e = exp_bits.pop_front();
                    check($sformatf("dacdat_bit%0d", bit_no), 64'(AUD_DACDAT), 64'(e));
                end
                bit_no++;
            end
        end
    end

    // Underflow monitor: counts pulses and rejects any pulse wider than 1 cycle.
    initial begin
        bit uf_prev = 0;
        forever begin
            @(negedge CLOCK_50);
            if (dac_underflow) begin
                uf_seen++;
                check("underflow_width", 64'(uf_prev), 64'(0));
            end
            uf_prev = dac_underflow;
        end
    end

    task automatic push_pair(input logic [DW-1:0] pl, input logic [DW-1:0] pr);
        bit acc;
        acc = (mq.size() < DEPTH);
        check("allowed_pre_write", 64'(audio_out_allowed), 64'(acc));
        left_channel_audio_out  = pl;
        right_channel_audio_out = pr;
        write_audio_out = 1'b1;
        wait_n(1);
        write_audio_out = 1'b0;
        if (acc) mq.push_back({pl, pr});
        $display("push L=%08h R=%08h %s (model depth %0d)", pl, pr, acc ? "accepted" : "dropped", mq.size());
    endtask

    // BCLK cycles with LRCK held: the line must stay 0 once a word is shifted out.
    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            AUD_BCLK = 1'b0;
            wait_n(HALF);
            exp_bits.push_back(1'b0);
            AUD_BCLK = 1'b1;
            wait_n(HALF);
        end
    endtask

    // One LRCK frame of 2*DW BCLK periods. Optionally a write lands in the
    // same cycle as the pop, or reset is pulsed just before bit rst_at.
    task automatic run_frame(input int rst_at, input bit cpush, input logic [2*DW-1:0] cdata);
        logic [2*DW-1:0] w;
        bit acc;
        acc = (mq.size() < DEPTH);
        if (mq.size() > 0) w = mq.pop_front();
        else begin
            w = '0;
            exp_uf++;
        end
        if (cpush && acc) mq.push_back(cdata);
        for (int k = 0; k < 2*DW; k++)
            exp_bits.push_back((rst_at >= 0 && k >= rst_at) ? 1'b0 : w[2*DW-1-k]);
        $display("frame %0d: L=%08h R=%08h%s%s", frame_no, w[2*DW-1:DW], w[DW-1:0],
                 cpush ? " +push" : "", (rst_at >= 0) ? " +reset" : "");
        frame_no++;
        for (int k = 0; k < 2*DW; k++) begin
            AUD_BCLK = 1'b0;
            if (k == 0 || k == DW) AUD_DACLRCK = (k == 0);
            if (k == 0 && cpush) begin
                wait_n(2);
                check("allowed_pre_pop", 64'(audio_out_allowed), 64'(acc));
                left_channel_audio_out  = cdata[2*DW-1:DW];
                right_channel_audio_out = cdata[DW-1:0];
                write_audio_out = 1'b1;
                wait_n(1);
                write_audio_out = 1'b0;
                wait_n(HALF-3);
            end else begin
                wait_n(HALF);
            end
            if (k == rst_at) begin
                check("dacdat_before_reset", 64'(AUD_DACDAT), 64'(w[2*DW-1-k]));
                reset = 1'b1;
                #1;
                check("dacdat_async_reset", 64'(AUD_DACDAT), 64'(0));
                mq.delete();
                wait_n(3);
                check_allowed("allowed_in_reset");
                reset = 1'b0;
                wait_n(1);
            end
            AUD_BCLK = 1'b1;
            wait_n(HALF);
        end
    endtask

    task automatic flush_with_push(input logic [2*DW-1:0] d);
        check_allowed("allowed_pre_flush");
        left_channel_audio_out  = d[2*DW-1:DW];
        right_channel_audio_out = d[DW-1:0];
        clear_audio_out_memory = 1'b1;
        write_audio_out = 1'b1;
        wait_n(1);
        clear_audio_out_memory = 1'b0;
        write_audio_out = 1'b0;
        mq.delete();
        $display("flush with concurrent push L=%08h R=%08h", d[2*DW-1:DW], d[DW-1:0]);
        wait_n(1);
        check_allowed("allowed_after_flush");
    endtask

    initial begin
        // Reset state.
        wait_n(4);
        check("reset_dacdat", 64'(AUD_DACDAT), 64'(0));
        check("reset_underflow", 64'(dac_underflow), 64'(0));
        check("reset_allowed", 64'(audio_out_allowed), 64'(1));
        reset = 1'b0;
        wait_n(2);
        mon_en = 1;
        idle_bits(2);

        // Single known frame.
        push_pair(32'h8000_0001, 32'h0000_FFFF);
        run_frame(-1, 0, '0);
        idle_bits(2);
        check("underflow_count_single", 64'(uf_seen), 64'(exp_uf));

        // Underflow frame on an empty FIFO.
        run_frame(-1, 0, '0);
        check("underflow_count_empty", 64'(uf_seen), 64'(exp_uf));

        // Fill past full; the ninth write is dropped.
        for (int i = 0; i < 9; i++) push_pair($urandom, $urandom);
        wait_n(1);
        check_allowed("allowed_when_full");
        run_frame(-1, 0, '0);
        check_allowed("allowed_after_pop_from_full");

        // Drain to three entries, then push and pop together across wrap.
        repeat (4) run_frame(-1, 0, '0);
        for (int i = 0; i < 12; i++) begin
            run_frame(-1, 1, {$urandom, $urandom});
            check("model_depth_const", 64'(audio_out_allowed), 64'(1));
        end

        // Flush at five entries while a frame is in flight.
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        fork
            run_frame(-1, 0, '0);
            begin
                wait_n(300);
                flush_with_push({$urandom, $urandom});
            end
        join
        run_frame(-1, 0, '0);
        check("underflow_after_flush", 64'(uf_seen), 64'(exp_uf));

        // Random traffic.
        for (int it = 0; it < 4; it++) begin
            int n, f;
            n = $urandom_range(0, 10);
            f = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) push_pair($urandom, $urandom);
            for (int i = 0; i < f; i++) run_frame(-1, 0, '0);
            check_allowed("allowed_random");
        end

        // Reset at bit 10 of the left word, then a fresh frame.
        push_pair($urandom | 32'h0020_0000, $urandom);
        push_pair($urandom, $urandom);
        run_frame(10, 0, '0);
        check_allowed("allowed_after_reset");
        idle_bits(2);
        push_pair($urandom, $urandom);
        run_frame(-1, 0, '0);
        idle_bits(2);

        check("underflow_count_final", 64'(uf_seen), 64'(exp_uf));
        check("bits_pending", 64'(exp_bits.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
